// File: rtl/data_mem_unit.sv
// ---------------------------------------------------------------------------
// data_mem_unit
// Data memory and memory-mapped I/O responder for the 8-bit CPU.
// A 16x8 data memory is accessed through the control unit's strobe pairs.
// Two addresses are I/O ports:
//    OUT_ADDR : a write also pushes into an output FIFO (valid/ready consumer)
//    IN_ADDR  : a read returns and pops a one-entry input mailbox
//
// Ports
//    clk_i        clock; all state updates on posedge
//    rst_i        asynchronous, active-low reset
//    DM_read      read strobe      (a read requires DM_read & OU_read)
//    OU_read      read qualifier
//    DM_write     write strobe     (a write requires DM_write & OU_write)
//    OU_write     write qualifier
//    DM_addr      word address
//    data_i       write data
//    data_o       registered read data
//    out_data_o   FIFO head (8'h00 when empty)
//    out_valid_o  FIFO non-empty
//    out_ready_i  consumer accepts head
//    in_data_i    producer data
//    in_valid_i   producer offers data
//    in_ready_o   mailbox empty
//    overflow_o   sticky: push dropped because FIFO full
//    underflow_o  sticky: input-port read while mailbox empty
//    proto_err_o  sticky: half strobe pair, or read and write together
// ---------------------------------------------------------------------------
module data_mem_unit #(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [3:0] OUT_ADDR   = 4'hF,
   parameter logic [3:0] IN_ADDR    = 4'hE
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       DM_read,
   input  logic       OU_read,
   input  logic       DM_write,
   input  logic       OU_write,
   input  logic [3:0] DM_addr,
   input  logic [7:0] data_i,
   output logic [7:0] data_o,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic       overflow_o,
   output logic       underflow_o,
   output logic       proto_err_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       mem_q  [16];
   logic [7:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       mbox_data_q;
   logic             mbox_full_q;
   logic             rd_q, wr_q;
   logic             ovf_q, unf_q, perr_q;

   logic rd, wr, rd_ok, wr_ok, rd_first, wr_first;
   logic half_strobe, conflict;
   logic fifo_full, fifo_valid, fifo_pop, push_req, fifo_push, ovf_evt;
   logic in_sel, mbox_pop, mbox_load, unf_evt;

   // Strobe decode
   always_comb begin
      rd          = DM_read & OU_read;
      wr          = DM_write & OU_write;
      conflict    = rd & wr;
      half_strobe = (DM_read ^ OU_read) | (DM_write ^ OU_write);
      rd_ok       = rd & ~wr;
      wr_ok       = wr & ~rd;
      // The control unit holds a read for two cycles; side effects fire once.
      rd_first    = rd & ~rd_q;
      wr_first    = wr & ~wr_q;
   end

   // FIFO / mailbox control
   always_comb begin
      fifo_full  = (cnt_q == FIFO_DEPTH[CNT_W-1:0]);
      fifo_valid = (cnt_q != '0);
      fifo_pop   = fifo_valid & out_ready_i;
      push_req   = wr_ok & wr_first & (DM_addr == OUT_ADDR);
      // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
      fifo_push  = push_req & (~fifo_full | fifo_pop);
      ovf_evt    = push_req & fifo_full & ~fifo_pop;
      in_sel     = rd_ok & (DM_addr == IN_ADDR);
      mbox_pop   = in_sel & rd_first & mbox_full_q;
      unf_evt    = in_sel & rd_first & ~mbox_full_q;
      mbox_load  = in_valid_i & ~mbox_full_q;
   end

   // Next-state for FIFO pointers, count and read data
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (rd_ok) begin
         if (DM_addr == IN_ADDR) begin
            // The first cycle captures the mailbox (or 00 if empty); the second
            // cycle of the same read keeps that value since the entry is gone.
            if (rd_first) data_d = mbox_full_q ? mbox_data_q : 8'h00;
         end else begin
            data_d = mem_q[DM_addr];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 8'h00;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         data_q      <= 8'h00;
         mbox_data_q <= 8'h00;
         mbox_full_q <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         perr_q      <= 1'b0;
      end else begin
         if (wr_ok) mem_q[DM_addr] <= data_i;
         if (fifo_push) fifo_q[wr_ptr_q] <= data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         if (mbox_load) begin
            mbox_data_q <= in_data_i;
            mbox_full_q <= 1'b1;
         end else if (mbox_pop) begin
            mbox_full_q <= 1'b0;
         end
         rd_q <= rd;
         wr_q <= wr;
         if (ovf_evt)                 ovf_q  <= 1'b1;
         if (unf_evt)                 unf_q  <= 1'b1;
         if (conflict || half_strobe) perr_q <= 1'b1;
      end
   end

   assign data_o      = data_q;
   assign out_valid_o = fifo_valid;
   assign out_data_o  = fifo_valid ? fifo_q[rd_ptr_q] : 8'h00;
   assign in_ready_o  = ~mbox_full_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;
   assign proto_err_o = perr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_unit
// Directed, table-driven bench for data_mem_unit. Each table row drives one
// clock cycle of strobes/handshakes and lists the outputs expected just after
// that posedge. Asynchronous reset mid-drain is exercised by hand afterwards.
// ---------------------------------------------------------------------------
module tb_data_mem_unit;

   localparam int OP_I = 0;  // idle
   localparam int OP_R = 1;  // read  (DM_read & OU_read)
   localparam int OP_W = 2;  // write (DM_write & OU_write)
   localparam int OP_H = 3;  // half write (DM_write only)

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       DM_read, OU_read, DM_write, OU_write;
   logic [3:0] DM_addr;
   logic [7:0] data_i, data_o, out_data_o, in_data_i;
   logic       out_valid_o, out_ready_i, in_valid_i, in_ready_o;
   logic       overflow_o, underflow_o, proto_err_o;

   always #5 clk_i = ~clk_i;

   data_mem_unit dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .DM_read     (DM_read),
      .OU_read     (OU_read),
      .DM_write    (DM_write),
      .OU_write    (OU_write),
      .DM_addr     (DM_addr),
      .data_i      (data_i),
      .data_o      (data_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o),
      .proto_err_o (proto_err_o)
   );

   typedef struct {
      string      name;
      int         op;
      logic [3:0] addr;
      logic [7:0] din;
      logic       ready;
      logic       inv;
      logic [7:0] ind;
      logic [7:0] e_data;
      logic       e_valid;
      logic [7:0] e_head;
      logic       e_inrdy;
      logic [2:0] e_flags;   // {overflow, underflow, proto_err}
   } vec_t;

   vec_t vq[$];
   int   applied     = 0;
   int   miscompares = 0;

   function automatic vec_t mk(string n, int op, logic [3:0] a, logic [7:0] d,
                               logic r, logic iv, logic [7:0] id,
                               logic [7:0] ed, logic ev, logic [7:0] eh,
                               logic eir, logic [2:0] ef);
      vec_t v;
      v.name = n; v.op = op; v.addr = a; v.din = d; v.ready = r;
      v.inv = iv; v.ind = id; v.e_data = ed; v.e_valid = ev;
      v.e_head = eh; v.e_inrdy = eir; v.e_flags = ef;
      return v;
   endfunction

   task automatic drive(input int op, input logic [3:0] a, input logic [7:0] d,
                        input logic r, input logic iv, input logic [7:0] id);
      DM_read     = (op == OP_R);
      OU_read     = (op == OP_R);
      DM_write    = (op == OP_W) || (op == OP_H);
      OU_write    = (op == OP_W);
      DM_addr     = a;
      data_i      = d;
      out_ready_i = r;
      in_valid_i  = iv;
      in_data_i   = id;
   endtask

   task automatic check(input string n, input logic [7:0] ed, input logic ev,
                        input logic [7:0] eh, input logic eir, input logic [2:0] ef);
      logic [2:0] flags;
      flags = {overflow_o, underflow_o, proto_err_o};
      applied++;
      if ({data_o, out_valid_o, out_data_o, in_ready_o, flags} !== {ed, ev, eh, eir, ef}) begin
         miscompares++;
         $display("FAIL %s: got data_o=%h valid=%b head=%h in_ready=%b flags=%b, want data_o=%h valid=%b head=%h in_ready=%b flags=%b",
                  n, data_o, out_valid_o, out_data_o, in_ready_o, flags, ed, ev, eh, eir, ef);
      end else begin
         $display("ok   %s: data_o=%h valid=%b head=%h in_ready=%b flags=%b",
                  n, data_o, out_valid_o, out_data_o, in_ready_o, flags);
      end
   endtask

   task automatic apply(input vec_t v);
      drive(v.op, v.addr, v.din, v.ready, v.inv, v.ind);
      @(posedge clk_i);
      #1;
      check(v.name, v.e_data, v.e_valid, v.e_head, v.e_inrdy, v.e_flags);
   endtask

   initial begin
      // ---- table: name, op, addr, din, ready, in_valid, in_data | data, valid, head, in_ready, flags
      // Basic write then two-cycle read
      vq.push_back(mk("wr3_5A",  OP_W, 4'h3, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b000));
      vq.push_back(mk("rd3_a",   OP_R, 4'h3, 8'h00, 0, 0, 8'h00, 8'h5A, 0, 8'h00, 1, 3'b000));
      vq.push_back(mk("rd3_b",   OP_R, 4'h3, 8'h00, 0, 0, 8'h00, 8'h5A, 0, 8'h00, 1, 3'b000));
      vq.push_back(mk("hold",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 0, 8'h00, 1, 3'b000));
      // Fill FIFO, then push AA while full with a simultaneous pop
      vq.push_back(mk("pushA01", OP_W, 4'hF, 8'h01, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushA02", OP_W, 4'hF, 8'h02, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushA03", OP_W, 4'hF, 8'h03, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushA04", OP_W, 4'hF, 8'h04, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushAA",  OP_W, 4'hF, 8'hAA, 1, 0, 8'h00, 8'h5A, 1, 8'h02, 1, 3'b000));
      vq.push_back(mk("drainA3", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'h03, 1, 3'b000));
      vq.push_back(mk("drainA4", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'h04, 1, 3'b000));
      vq.push_back(mk("drainAA", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'hAA, 1, 3'b000));
      vq.push_back(mk("drainE",  OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 0, 8'h00, 1, 3'b000));
      // Five pushes with consumer stalled -> overflow on the fifth
      vq.push_back(mk("pushB01", OP_W, 4'hF, 8'h01, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushB02", OP_W, 4'hF, 8'h02, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushB03", OP_W, 4'hF, 8'h03, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushB04", OP_W, 4'hF, 8'h04, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b000));
      vq.push_back(mk("pushB05", OP_W, 4'hF, 8'h05, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b100));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 8'h01, 1, 3'b100));
      vq.push_back(mk("drainB2", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'h02, 1, 3'b100));
      vq.push_back(mk("drainB3", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'h03, 1, 3'b100));
      vq.push_back(mk("drainB4", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 1, 8'h04, 1, 3'b100));
      vq.push_back(mk("drainBE", OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h5A, 0, 8'h00, 1, 3'b100));
      // Output address reads back the last value written (even the dropped push)
      vq.push_back(mk("rdF",     OP_R, 4'hF, 8'h00, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1, 3'b100));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h05, 0, 8'h00, 1, 3'b100));
      // Mailbox: load C3, two-cycle read pops once
      vq.push_back(mk("loadC3",  OP_I, 4'h0, 8'h00, 0, 1, 8'hC3, 8'h05, 0, 8'h00, 0, 3'b100));
      vq.push_back(mk("rdE_a",   OP_R, 4'hE, 8'h00, 0, 0, 8'h00, 8'hC3, 0, 8'h00, 1, 3'b100));
      vq.push_back(mk("rdE_b",   OP_R, 4'hE, 8'h00, 0, 0, 8'h00, 8'hC3, 0, 8'h00, 1, 3'b100));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'hC3, 0, 8'h00, 1, 3'b100));
      // Mailbox empty read -> 00 and underflow
      vq.push_back(mk("rdEe_a",  OP_R, 4'hE, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b110));
      vq.push_back(mk("rdEe_b",  OP_R, 4'hE, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b110));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b110));
      // Half write is ignored but flags a protocol error
      vq.push_back(mk("wr2_77",  OP_W, 4'h2, 8'h77, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b110));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b110));
      vq.push_back(mk("half2",   OP_H, 4'h2, 8'h99, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b111));
      vq.push_back(mk("rd2",     OP_R, 4'h2, 8'h00, 0, 0, 8'h00, 8'h77, 0, 8'h00, 1, 3'b111));
      vq.push_back(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h77, 0, 8'h00, 1, 3'b111));

      // ---- reset
      rst_i = 1'b0;
      drive(OP_I, 4'h0, 8'h00, 0, 0, 8'h00);
      repeat (2) @(posedge clk_i);
      #1;
      check("reset", 8'h00, 0, 8'h00, 1, 3'b000);
      #2 rst_i = 1'b1;

      // ---- table
      for (int i = 0; i < vq.size(); i++) apply(vq[i]);

      // ---- asynchronous reset mid FIFO drain, with mailbox full
      apply(mk("pushC10", OP_W, 4'hF, 8'h10, 0, 0, 8'h00, 8'h77, 1, 8'h10, 1, 3'b111));
      apply(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h77, 1, 8'h10, 1, 3'b111));
      apply(mk("pushC20", OP_W, 4'hF, 8'h20, 0, 1, 8'h5E, 8'h77, 1, 8'h10, 0, 3'b111));
      apply(mk("drainC",  OP_I, 4'h0, 8'h00, 1, 0, 8'h00, 8'h77, 1, 8'h20, 0, 3'b111));
      #2 rst_i = 1'b0;   // between edges: outputs must clear without a clock
      #1;
      check("async_rst", 8'h00, 0, 8'h00, 1, 3'b000);
      @(posedge clk_i);
      #3 rst_i = 1'b1;
      // Memory contents were cleared by the reset
      apply(mk("rd2_rst", OP_R, 4'h2, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b000));
      apply(mk("idle",    OP_I, 4'h0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b000));
      apply(mk("rdF_rst", OP_R, 4'hF, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 3'b000));

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
